// File: rtl/wbmem_pkg.sv
// Shared constants and response encoding for the Wishbone memory responder.
package wbmem_pkg;

  localparam int WB_DW      = 32;
  localparam int WB_SELW    = 4;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_e;

  // rd marks responses that carry read data; write acks and errors return zero
  typedef struct packed {
    rsp_e kind;
    logic rd;
  } rsp_t;

  localparam rsp_t RSP_IDLE = '{kind: RSP_NONE, rd: 1'b0};

endpackage

// File: rtl/wbmem_ram.sv
// Single-port synchronous RAM: byte-enable write, registered read-first output.
module wbmem_ram
  import wbmem_pkg::*;
#(
  parameter int WORDS     = 4096,
  parameter int ADDR_W    = 12,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WB_DW-1:0]   wdata,
  input  logic [WB_SELW-1:0] sel,
  output logic [WB_DW-1:0]   rdata
);

  // Both branches share the access logic; only the elaboration-time fill differs
  if (INIT_ZERO) begin : g_zero
    logic [WB_DW-1:0] mem [WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          for (int b = 0; b < WB_SELW; b++) begin
            if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
        rdata <= mem[addr];
      end
    end
  end else begin : g_plain
    logic [WB_DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          for (int b = 0; b < WB_SELW; b++) begin
            if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wbmem_responder.sv
// Wishbone B4 pipelined memory responder with wait states and range checking.
// Define WBMEM_RESPONDER_RDPIPE_EN to add an output register stage (latency 2).
module wbmem_responder
  import wbmem_pkg::*;
#(
  parameter int AW          = 30,
  parameter int MEM_WORDS   = 4096,
  parameter int WAIT_STATES = 0,
  parameter int INIT_ZERO   = 1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [WB_DW-1:0]   i_wb_data,
  input  logic [WB_SELW-1:0] i_wb_sel,
  output logic               o_wb_stall,
  output logic               o_wb_ack,
  output logic [WB_DW-1:0]   o_wb_data,
  output logic               o_wb_err
);

  localparam int                    RAM_AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AW:0]           MEM_LIMIT   = (AW+1)'(MEM_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_RELOAD = WAIT_CNT_W'(WAIT_STATES);

  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  rsp_t                  rsp_q, rsp_d;
  logic                  accept;
  logic                  in_range;
  logic [WB_DW-1:0]      ram_rdata;
  rsp_t                  rsp_out;
  logic [WB_DW-1:0]      data_out;

  assign o_wb_stall = (wait_cnt_q != '0);
  assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign in_range   = ({1'b0, i_wb_addr} < MEM_LIMIT);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_wb_cyc || accept) begin
      wait_cnt_d = WAIT_RELOAD;
    end else if (i_wb_stb && wait_cnt_q != '0) begin
      wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
    end
  end

  // No accept (including any cycle with cyc low) leaves the stage empty, which squashes
  always_comb begin
    rsp_d = RSP_IDLE;
    if (accept) begin
      rsp_d.kind = in_range ? RSP_ACK : RSP_ERR;
      rsp_d.rd   = in_range && !i_wb_we;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_cnt_q <= WAIT_RELOAD;
      rsp_q      <= RSP_IDLE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_q      <= rsp_d;
    end
  end

  wbmem_ram #(
    .WORDS    (MEM_WORDS),
    .ADDR_W   (RAM_AW),
    .INIT_ZERO(INIT_ZERO != 0)
  ) u_ram (
    .clk  (i_clk),
    .en   (accept && in_range),
    .we   (i_wb_we),
    .addr (i_wb_addr[RAM_AW-1:0]),
    .wdata(i_wb_data),
    .sel  (i_wb_sel),
    .rdata(ram_rdata)
  );

`ifdef WBMEM_RESPONDER_RDPIPE_EN
  rsp_t             out_rsp_q, out_rsp_d;
  logic [WB_DW-1:0] out_data_q, out_data_d;

  always_comb begin
    out_rsp_d  = RSP_IDLE;
    out_data_d = '0;
    if (i_wb_cyc) begin
      out_rsp_d = rsp_q;
      if (rsp_q.kind == RSP_ACK && rsp_q.rd) out_data_d = ram_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_rsp_q  <= RSP_IDLE;
      out_data_q <= '0;
    end else begin
      out_rsp_q  <= out_rsp_d;
      out_data_q <= out_data_d;
    end
  end

  assign rsp_out  = out_rsp_q;
  assign data_out = out_data_q;
`else
  assign rsp_out  = rsp_q;
  assign data_out = (rsp_q.kind == RSP_ACK && rsp_q.rd) ? ram_rdata : '0;
`endif

  assign o_wb_ack  = (rsp_out.kind == RSP_ACK);
  assign o_wb_err  = (rsp_out.kind == RSP_ERR);
  assign o_wb_data = o_wb_ack ? data_out : '0;

endmodule

// File: tb/tb_wbmem_responder.sv
// Bench for wbmem_responder: directed literal checks plus randomized traffic
// compared every cycle against a cycle-indexed response schedule and word-array memory.
module tb_wbmem_responder;

`ifdef WBMEM_RESPONDER_RDPIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int MEM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall, ack, err;
  logic [31:0] rdata;

  logic        ws_cyc, ws_stb, ws_we;
  logic [29:0] ws_addr;
  logic [31:0] ws_wdata;
  logic [3:0]  ws_sel;
  logic        ws_stall, ws_ack, ws_err;
  logic [31:0] ws_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [MEM_WORDS] = '{default: 32'h0};
  int          sched_kind [4] = '{default: 0};
  logic        sched_rd   [4] = '{default: 1'b0};
  logic [31:0] sched_data [4] = '{default: 32'h0};
  int          tick = 0;

  always #5 clk = ~clk;

  wbmem_responder #(.AW(30), .MEM_WORDS(MEM_WORDS), .WAIT_STATES(0), .INIT_ZERO(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata), .o_wb_err(err)
  );

  wbmem_responder #(.AW(30), .MEM_WORDS(12), .WAIT_STATES(3), .INIT_ZERO(1)) dut_ws (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(ws_cyc), .i_wb_stb(ws_stb), .i_wb_we(ws_we), .i_wb_addr(ws_addr),
    .i_wb_data(ws_wdata), .i_wb_sel(ws_sel),
    .o_wb_stall(ws_stall), .o_wb_ack(ws_ack), .o_wb_data(ws_rdata), .o_wb_err(ws_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [29:0] a, input logic [31:0] d,
                               input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic doSingle(input logic w, input logic [29:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic e_ack, input logic e_err,
                          input logic [31:0] e_data, input string name);
    applyStimulus(w, a, d, s);
    idleBus();
    repeat (L-1) @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_ack"}, 32'(ack), 32'(e_ack));
    checkOutput({name, "_err"}, 32'(err), 32'(e_err));
    if (!(w && e_ack)) checkOutput({name, "_data"}, rdata, e_data);
    @(posedge clk);
    #1;
  endtask

  // Reference: each accepted request books its outcome L cycles ahead; cyc low cancels bookings
  always @(negedge clk) begin : compare_proc
    int   s, d;
    logic e_ack, e_err;
    s = tick % 4;
    if (!rst_n) for (int i = 0; i < 4; i++) sched_kind[i] = 0;
    e_ack = (sched_kind[s] == 1);
    e_err = (sched_kind[s] == 2);
    checkOutput("model_ack", 32'(ack), 32'(e_ack));
    checkOutput("model_err", 32'(err), 32'(e_err));
    checkOutput("model_stall", 32'(stall), 32'h0);
    if (!e_ack) checkOutput("model_data_idle", rdata, 32'h0);
    else if (sched_rd[s]) checkOutput("model_rdata", rdata, sched_data[s]);
    sched_kind[s] = 0;
    if (rst_n && !cyc) begin
      sched_kind[(s+1)%4] = 0;
      sched_kind[(s+2)%4] = 0;
    end else if (rst_n && stb) begin
      d = (tick + L) % 4;
      sched_rd[d]   = 1'b0;
      sched_data[d] = 32'h0;
      if (addr >= 30'(MEM_WORDS)) begin
        sched_kind[d] = 2;
      end else begin
        sched_kind[d] = 1;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (sel[b]) model_mem[addr[11:0]][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          sched_rd[d]   = 1'b1;
          sched_data[d] = model_mem[addr[11:0]];
        end
      end
    end
    tick++;
  end

  initial begin
    int r;
    rst_n = 1'b1;
    cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0; sel = '0;
    ws_cyc = 0; ws_stb = 0; ws_we = 0; ws_addr = '0; ws_wdata = '0; ws_sel = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_ack", 32'(ack), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_data", rdata, 32'h0);
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_ws_stall", 32'(ws_stall), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    doSingle(1'b1, 30'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0, "wr_10");
    doSingle(1'b0, 30'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF, "rd_10");

    doSingle(1'b1, 30'h20, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0, "wr_20_full");
    doSingle(1'b1, 30'h20, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'h0, "wr_20_sel5");
    doSingle(1'b0, 30'h20, 32'h0, 4'h0, 1'b1, 1'b0, 32'h11BB33DD, "rd_20_bytesel");

    doSingle(1'b1, 30'd4096, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0, "oor_wr_4096");
    doSingle(1'b0, 30'h0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, "rd_0_unchanged");
    doSingle(1'b0, 30'h3FFF_FFFF, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, "oor_rd_top");
    doSingle(1'b1, 30'h7, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, "wr_sel0");

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 30'(i), 32'h100 + 32'(i), 4'hF);
    idleBus();
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 30'(i), 32'h0, 4'hF);
        idleBus();
      end
      begin
        repeat (L) @(posedge clk);
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          checkOutput("burst_ack", 32'(ack), 32'h1);
          checkOutput("burst_data", rdata, 32'h100 + 32'(j));
        end
      end
    join
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 30'h0, 32'h0, 4'hF);
    applyStimulus(1'b0, 30'h1, 32'h0, 4'hF);
    cyc = 1'b0; stb = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_ack", 32'(ack), 32'h0);
      checkOutput("abort_err", 32'(err), 32'h0);
    end
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 30'h10, 32'h0, 4'hF);
    applyStimulus(1'b0, 30'h20, 32'h0, 4'hF);
    idleBus();
    repeat (L-1) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_ack", 32'(ack), 32'h1);
    checkOutput("pre_reset_data", rdata, 32'h11BB33DD);
    #1 rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    #1;
    checkOutput("mid_reset_ack", 32'(ack), 32'h0);
    checkOutput("mid_reset_err", 32'(err), 32'h0);
    checkOutput("mid_reset_data", rdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    doSingle(1'b0, 30'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF, "after_reset_rd");

    // Wait-state instance: stb held across two reads, accepts expected at cycles 3 and 7
    for (int k = 0; k <= 10; k++) begin
      ws_cyc  = 1'b1;
      ws_stb  = (k <= 7);
      ws_addr = (k <= 3) ? 30'h0 : 30'h1;
      @(negedge clk);
      if (k <= 7) checkOutput("ws_stall", 32'(ws_stall), 32'(k != 3 && k != 7));
      checkOutput("ws_ack", 32'(ws_ack), 32'(k == 3 + L || k == 7 + L));
      checkOutput("ws_err", 32'(ws_err), 32'h0);
      checkOutput("ws_data", ws_rdata, 32'h0);
      @(posedge clk);
      #1;
    end
    ws_cyc = 1'b0; ws_stb = 1'b0;

    repeat (1500) begin
      cyc   = ($urandom_range(0, 15) != 0);
      stb   = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      sel   = 4'($urandom_range(0, 15));
      r     = $urandom_range(0, 9);
      if (r < 6)       addr = 30'($urandom_range(0, 15));
      else if (r < 8)  addr = 30'($urandom_range(4090, 4101));
      else if (r == 8) addr = 30'($urandom_range(16, 4095));
      else             addr = 30'($urandom);
      @(posedge clk);
      #1;
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
